// File: rtl/fir_pkg.sv
// Shared types and width helpers for the multi-channel FIR filter.
package fir_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } fir_state_e;

    function automatic int clog2(input int value);
        int r;
        int n;
        r = 0;
        n = 1;
        while (n < value) begin
            n = n << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits for single-entry tables.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

    // Growth of clog2(taps) bits absorbs the sum of TAPS full-precision products.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate: the product of a_i and b_i is added into a
// registered accumulator each enabled clock; clr_i restarts the sum at zero.
module fir_mac
    import fir_pkg::*;
#(
    parameter int A_W   = DEF_DATA_W,
    parameter int B_W   = DEF_COEF_W,
    parameter int ACC_W = acc_width(DEF_DATA_W, DEF_COEF_W, 16)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [ACC_W-1:0] acc_o
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   a_ext;
    logic signed [P_W-1:0]   b_ext;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] acc_q;

    // Operands are sign-extended to the full product width so no bits are lost.
    assign a_ext = P_W'(a_i);
    assign b_ext = P_W'(b_i);
    assign prod  = a_ext * b_ext;
    assign acc_o = acc_q;

    // Accumulator register; clear wins over enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/fir_filter_mc.sv
// Multi-channel FIR: per-channel delay lines, one shared coefficient set,
// one time-multiplexed MAC evaluating every channel per accepted vector.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a vector; coefficient writes accepted
// MAC     | one tap of the current channel per clock
// EMIT    | register result of current channel, advance to next channel
// DONE    | one settling cycle before returning to IDLE
module fir_filter_mc
    import fir_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int TAPS     = 16,
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int COEF_W   = DEF_COEF_W,
    localparam int ACC_W    = acc_width(DATA_W, COEF_W, TAPS),
    localparam int TAP_W    = idx_width(TAPS),
    localparam int CH_W     = idx_width(CHANNELS)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [CHANNELS*DATA_W-1:0]   in_data_i,
    input  logic                         coef_we_i,
    input  logic [TAP_W-1:0]             coef_addr_i,
    input  logic signed [COEF_W-1:0]     coef_data_i,
    output logic                         out_valid_o,
    output logic [CH_W-1:0]              out_chan_o,
    output logic signed [ACC_W-1:0]      out_data_o,
    output logic                         overrun_o
);

    localparam logic [TAP_W-1:0] K_LAST  = TAP_W'(TAPS - 1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(CHANNELS - 1);

    fir_state_e state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [TAP_W-1:0] k_q, k_d;

    logic signed [DATA_W-1:0] dl_q   [CHANNELS][TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];

    logic                     accept;
    logic                     coef_wr;
    logic                     emit;
    logic                     mac_clr;
    logic                     mac_en;
    logic                     overrun_d;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [COEF_W-1:0] mac_b;
    logic signed [ACC_W-1:0]  mac_acc;

    logic                     out_valid_q;
    logic [CH_W-1:0]          out_chan_q;
    logic signed [ACC_W-1:0]  out_data_q;
    logic                     overrun_q;

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = out_valid_q;
    assign out_chan_o  = out_chan_q;
    assign out_data_o  = out_data_q;
    assign overrun_o   = overrun_q;

    assign mac_a = dl_q[ch_q][k_q];
    assign mac_b = coef_q[k_q];

    fir_mac #(
        .A_W  (DATA_W),
        .B_W  (COEF_W),
        .ACC_W(ACC_W)
    ) u_mac (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (mac_a),
        .b_i   (mac_b),
        .acc_o (mac_acc)
    );

    // Next-state, channel/tap sequencing and datapath strobes.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        k_d       = k_q;
        accept    = 1'b0;
        coef_wr   = 1'b0;
        emit      = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        overrun_d = in_valid_i && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                coef_wr = coef_we_i;
                if (in_valid_i) begin
                    accept  = 1'b1;
                    mac_clr = 1'b1;
                    ch_d    = '0;
                    k_d     = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = ST_EMIT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_EMIT: begin
                emit = 1'b1;
                if (ch_q == CH_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    k_d     = '0;
                    mac_clr = 1'b1;
                    state_d = ST_MAC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Delay lines, coefficient file, sequencing counters and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int t = 0; t < TAPS; t++) begin
                    dl_q[c][t] <= '0;
                end
            end
            for (int t = 0; t < TAPS; t++) begin
                coef_q[t] <= '0;
            end
            ch_q        <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            ch_q        <= ch_d;
            k_q         <= k_d;
            out_valid_q <= emit;
            overrun_q   <= overrun_d;
            // A write on the accept edge lands before the first MAC cycle reads it.
            if (coef_wr) begin
                coef_q[coef_addr_i] <= coef_data_i;
            end
            if (accept) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    for (int t = TAPS - 1; t > 0; t--) begin
                        dl_q[c][t] <= dl_q[c][t-1];
                    end
                    dl_q[c][0] <= in_data_i[c*DATA_W +: DATA_W];
                end
            end
            if (emit) begin
                out_data_q <= mac_acc;
                out_chan_q <= ch_q;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_mc.sv
// Directed plus randomized bench for fir_filter_mc (2 channels, 4 taps).
module tb_fir_filter_mc;

    localparam int CH = 2;
    localparam int TP = 4;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int AW = 34;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             coef_we = 1'b0;
    logic [CH*DW-1:0] in_data = '0;
    logic [1:0]       coef_addr = '0;
    logic [CW-1:0]    coef_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic             overrun;
    logic [0:0]       out_chan;
    logic [AW-1:0]    out_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ovr_cnt = 0;
    int e0 = 0;

    int     h_m[TP];
    int     x_m[CH][TP];
    longint exp_y[CH];

    int            q_chan[$];
    logic [AW-1:0] q_data[$];
    int            q_cyc[$];

    fir_filter_mc #(
        .CHANNELS(CH),
        .TAPS    (TP),
        .DATA_W  (DW),
        .COEF_W  (CW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .coef_we_i  (coef_we),
        .coef_addr_i(coef_addr),
        .coef_data_i(coef_data),
        .out_valid_o(out_valid),
        .out_chan_o (out_chan),
        .out_data_o (out_data),
        .overrun_o  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            q_chan.push_back(int'(out_chan));
            q_data.push_back(out_data);
            q_cyc.push_back(cyc);
        end
        if (overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < TP; k++) begin
            h_m[k] = 0;
            for (int c = 0; c < CH; c++) x_m[c][k] = 0;
        end
    endtask

    // Reference: shift each channel history, then y_c = sum h[k]*x_c[n-k].
    task automatic model_accept(input logic signed [DW-1:0] d0, input logic signed [DW-1:0] d1);
        for (int c = 0; c < CH; c++) begin
            for (int k = TP - 1; k > 0; k--) x_m[c][k] = x_m[c][k-1];
        end
        x_m[0][0] = int'(d0);
        x_m[1][0] = int'(d1);
        for (int c = 0; c < CH; c++) begin
            exp_y[c] = 0;
            for (int k = 0; k < TP; k++) exp_y[c] += longint'(h_m[k]) * longint'(x_m[c][k]);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 64'(in_ready), 64'd1);
    endtask

    task automatic set_coef(input int addr, input logic signed [CW-1:0] val);
        wait_ready();
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 2'(addr);
        coef_data = val;
        h_m[addr] = int'(val);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    // poke_kind 1: extra in_valid at negedge poke_at; 2: coef write addr0=9 there.
    task automatic run_vec(input logic signed [DW-1:0] d0, input logic signed [DW-1:0] d1,
                           input int poke_at, input int poke_kind,
                           input bit cw, input int cw_addr, input logic signed [CW-1:0] cw_val);
        int            ovr0;
        logic [AW-1:0] ev;
        wait_ready();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = {d1, d0};
        if (cw) begin
            coef_we      = 1'b1;
            coef_addr    = 2'(cw_addr);
            coef_data    = cw_val;
            h_m[cw_addr] = int'(cw_val);
        end
        model_accept(d0, d1);
        ovr0 = ovr_cnt;
        @(posedge clk);
        #1;
        e0       = cyc;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == poke_at && poke_kind == 1) begin
                in_valid = 1'b1;
                in_data  = 32'($urandom);
            end else if (n == poke_at && poke_kind == 2) begin
                coef_we   = 1'b1;
                coef_addr = 2'd0;
                coef_data = 16'sd9;
            end else begin
                in_valid = 1'b0;
                coef_we  = 1'b0;
            end
            if (n == 11) chk("busy_before_e11", 64'(in_ready), 64'd0);
            if (n == 12) chk("ready_after_e11", 64'(in_ready), 64'd1);
        end
        chk("overrun_pulses", 64'(ovr_cnt - ovr0), (poke_kind == 1) ? 64'd1 : 64'd0);
        chk("result_count", 64'(q_data.size()), 64'(CH));
        for (int i = 0; i < CH && i < q_data.size(); i++) begin
            ev = exp_y[i][AW-1:0];
            chk("out_chan", 64'(q_chan[i]), 64'(i));
            chk("out_data", 64'(q_data[i]), 64'(ev));
            chk("out_timing", 64'(q_cyc[i] - e0), 64'((i + 1) * (TP + 1)));
        end
        q_chan.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic vec(input logic signed [DW-1:0] d0, input logic signed [DW-1:0] d1);
        run_vec(d0, d1, 0, 0, 1'b0, 0, 16'sd0);
    endtask

    task automatic reset_mid();
        wait_ready();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (14) @(negedge clk);
        chk("rst_no_result", 64'(q_data.size()), 64'd0);
        chk("rst_ready_after", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_chan", 64'(out_chan), 64'd0);
        q_chan.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    initial begin
        logic signed [DW-1:0] r0;
        logic signed [DW-1:0] r1;
        logic signed [CW-1:0] rc;
        model_reset();

        // Reset state.
        #2;
        rst_n = 1'b0;
        #10;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_chan", 64'(out_chan), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_overrun", 64'(overrun), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Impulse response.
        for (int k = 0; k < TP; k++) set_coef(k, 16'(k + 1));
        vec(16'sd100, 16'sd0);
        for (int i = 0; i < 4; i++) vec(16'sd0, 16'sd0);

        // Channel independence and sign.
        for (int k = 0; k < TP; k++) set_coef(k, 16'sd1);
        for (int i = 0; i < 4; i++) vec(16'sd7, -16'sd5);

        // Full-scale extreme.
        for (int k = 0; k < TP; k++) set_coef(k, -16'sd32768);
        for (int i = 0; i < 4; i++) vec(-16'sd32768, -16'sd32768);
        chk("fullscale_2pow32", 64'(exp_y[0]), 64'h1_0000_0000);

        // Overrun while busy.
        for (int k = 0; k < TP; k++) set_coef(k, 16'(k + 1));
        run_vec(16'sd11, -16'sd13, 3, 1, 1'b0, 0, 16'sd0);

        // Coefficient write rules.
        set_coef(0, 16'sd1);
        for (int k = 1; k < TP; k++) set_coef(k, 16'sd0);
        run_vec(16'sd3, 16'sd4, 2, 2, 1'b0, 0, 16'sd0);
        run_vec(16'sd2, 16'sd0, 0, 0, 1'b1, 0, 16'sd5);

        // Randomized vectors and coefficient updates.
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                rc = 16'($urandom);
                set_coef(int'($urandom_range(0, TP - 1)), rc);
            end
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            rc = 16'($urandom);
            run_vec(r0, r1, 0, 0, ($urandom_range(0, 3) == 0), int'($urandom_range(0, TP - 1)), rc);
        end

        // Reset mid-MAC, then impulse with reloaded coefficients.
        reset_mid();
        for (int k = 0; k < TP; k++) set_coef(k, 16'(k + 1));
        vec(16'sd100, 16'sd0);
        for (int i = 0; i < 4; i++) vec(16'sd0, 16'sd0);

        // Reset clears the coefficient file.
        reset_mid();
        vec(16'sd123, -16'sd45);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
